// File: rtl/run_tick_ctrl.sv
// Run/pause and single-step timebase for the display digit counters.
// Both pushbuttons are synchronized and debounced before reaching the tick FSM.
module run_tick_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int CNT_W      = 26,
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20
) (
    input  logic CLOCK_50,
    input  logic Resetn,
    input  logic key_run_n,
    input  logic key_step_n,
    output logic tick,
    output logic running
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } state_t;

    // Key index 0 = run/pause, 1 = single-step.
    logic [1:0]            key_raw;
    logic [1:0]            sync_a;
    logic [1:0]            sync_b;
    logic [1:0]            deb_lvl;
    logic [1:0][DEB_W-1:0] deb_cnt;
    logic [1:0]            press;

    logic                  run_evt;
    logic                  step_evt;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      presc_q;
    logic [CNT_W-1:0]      presc_d;
    logic                  tick_q;
    logic                  tick_d;

    assign key_raw = {key_step_n, key_run_n};

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
        end else begin
            sync_a <= key_raw;
            sync_b <= sync_a;
        end
    end

    // The level must disagree for DEB_CYCLES consecutive samples before it is accepted.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            deb_lvl <= 2'b11;
            deb_cnt <= '0;
            press   <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                press[k] <= 1'b0;
                if (sync_b[k] == deb_lvl[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    deb_cnt[k] <= '0;
                    deb_lvl[k] <= sync_b[k];
                    press[k]   <= ~sync_b[k];
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
                end
            end
        end
    end

    assign run_evt  = press[0];
    assign step_evt = press[1];

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= RUNNING;
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // A run event takes priority over a step event in the same cycle.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        case (state_q)
            RUNNING: begin
                if (run_evt) begin
                    state_d = PAUSED;
                end else if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end
            PAUSED: begin
                if (run_evt) begin
                    state_d = RUNNING;
                    presc_d = '0;
                end else if (step_evt) begin
                    tick_d = 1'b1;
                end
            end
            default: begin
                state_d = RUNNING;
                presc_d = '0;
            end
        endcase
    end

    assign tick    = tick_q;
    assign running = (state_q == RUNNING);

endmodule

// File: tb/tb_run_tick_ctrl.sv
// Scoreboard bench for run_tick_ctrl: stimulus queues expected tick cycles,
// a negedge monitor pops and compares each observed tick.
module tb_run_tick_ctrl;

    localparam int TD = 10;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rstn;
    logic krun;
    logic kstep;
    logic tick;
    logic running;

    run_tick_ctrl #(
        .TICK_DIV  (TD),
        .CNT_W     (4),
        .DEB_CYCLES(DC),
        .DEB_W     (3)
    ) dut (
        .CLOCK_50  (clk),
        .Resetn    (rstn),
        .key_run_n (krun),
        .key_step_n(kstep),
        .tick      (tick),
        .running   (running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   at;
        logic run;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    logic tick_d  = 1'b0;

    function automatic void chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    task automatic at(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ticks(input int base, input int n, input logic run);
        exp_t e;
        for (int i = 1; i <= n; i++) begin
            e.at  = base + TD * i;
            e.run = run;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every observed tick must match the head of the expectation queue.
    always @(negedge clk) begin : mon
        exp_t e;
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", cyc, -1);
            end else begin
                e = exp_q.pop_front();
                chk("tick_cycle", cyc, e.at);
                chk("tick_running", int'(running), int'(e.run));
            end
            if (tick_d === 1'b1) chk("tick_double", int'(tick_d), 0);
        end
        tick_d = tick;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int r0, k, k2, k3, k4, k5, k7, k8;
        exp_t e;
        rstn  = 1'b0;
        krun  = 1'b1;
        kstep = 1'b1;

        // 1. free-running after reset
        at(3);
        r0   = cyc;
        rstn = 1'b1;
        chk("reset_running", int'(running), 1);
        chk("reset_tick", int'(tick), 0);
        push_ticks(r0, 26, 1'b1);

        // 2. three-cycle bounce must not register
        at(r0 + 212);
        krun = 1'b0;
        at(r0 + 215);
        krun = 1'b1;
        at(r0 + 262);
        chk("bounce_running", int'(running), 1);

        // 3. pause, idle 100 cycles, resume
        k    = cyc;
        krun = 1'b0;
        at(k + 6);
        chk("pause_latency_before", int'(running), 1);
        at(k + 7);
        chk("pause_running", int'(running), 0);
        at(k + 20);
        krun = 1'b1;
        at(k + 120);
        chk("pause_no_ticks", exp_q.size(), 0);
        chk("pause_still", int'(running), 0);

        k2   = cyc;
        krun = 1'b0;
        push_ticks(k2 + 7, 4, 1'b1);
        at(k2 + 7);
        chk("resume_running", int'(running), 1);
        at(k2 + 10);
        krun = 1'b1;
        k3   = k2 + 42;
        at(k3);
        krun = 1'b0;
        at(k3 + 7);
        chk("pause2_running", int'(running), 0);
        at(k3 + 10);
        krun = 1'b1;

        // 4. held step key while paused gives one tick
        k4    = k3 + 30;
        at(k4);
        e.at  = k4 + 7;
        e.run = 1'b0;
        exp_q.push_back(e);
        kstep = 1'b0;
        at(k4 + 50);
        kstep = 1'b1;
        at(k4 + 70);
        chk("step_running", int'(running), 0);
        chk("step_queue_empty", exp_q.size(), 0);

        // 5. step ignored while running; run+step together pauses without tick
        k5   = cyc;
        krun = 1'b0;
        push_ticks(k5 + 7, 5, 1'b1);
        at(k5 + 10);
        krun  = 1'b1;
        at(k5 + 20);
        kstep = 1'b0;
        at(k5 + 30);
        kstep = 1'b1;
        k7    = k5 + 52;
        at(k7);
        krun  = 1'b0;
        kstep = 1'b0;
        at(k7 + 7);
        chk("both_pause_running", int'(running), 0);
        at(k7 + 10);
        krun  = 1'b1;
        kstep = 1'b1;
        at(k7 + 30);
        chk("both_queue_empty", exp_q.size(), 0);
        chk("both_still_paused", int'(running), 0);

        // 6. reset mid-period at prescaler = 6
        k8   = cyc;
        krun = 1'b0;
        push_ticks(k8 + 7, 2, 1'b1);
        at(k8 + 10);
        krun = 1'b1;
        at(k8 + 33);
        rstn = 1'b0;
        at(k8 + 34);
        rstn = 1'b1;
        chk("midreset_tick", int'(tick), 0);
        chk("midreset_running", int'(running), 1);
        push_ticks(k8 + 34, 2, 1'b1);
        at(k8 + 60);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
